// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
//
// Reads the EX/MEM pipeline bundle, turns load/store ops into data-memory bus
// transactions (req/ready for the request, rvalid for read data), aligns and
// extends load data, and drives the MEM/WB bundle. stall freezes upstream
// stages while a memory op is in flight.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN): misaligned half/word
// accesses skip the bus, retire with wb_RegWrite=0, wb_C = faulting address and
// a one-cycle misalign pulse. Without the macro misalign is tied to 0 and the
// low address bits are simply dropped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ex_*                  EX/MEM bundle (address/ALU result, store data, control)
//   stall                 hold EX/MEM and earlier stages
//   dmem_req/we/addr/wdata/wstrb   bus request (addr word aligned, lanes replicated)
//   dmem_ready            request accepted
//   dmem_rvalid/rdata     read response
//   wb_*                  MEM/WB bundle
//   misalign              misaligned-access pulse (feature build only)

module mem_stage_lsu #(
    parameter logic [1:0] LOAD_SEL = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_C,
    input  logic [31:0] ex_rD2,
    input  logic        ex_wr,
    input  logic [31:0] ex_inst,
    input  logic        ex_bubble,
    input  logic [1:0]  ex_wD_sel,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_imm,
    input  logic        ex_RegWrite,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_C,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_pc4,
    output logic [31:0] wb_imm,
    output logic [31:0] wb_inst,
    output logic [1:0]  wb_wD_sel,
    output logic        wb_RegWrite,
    output logic        wb_bubble,
    output logic        misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        memop;
    logic        ex_mis;

    // Latched op fields, stable for the whole transaction.
    logic [31:0] op_addr_q, op_wdata_q, op_pc4_q, op_imm_q, op_inst_q, op_rdata_q;
    logic [1:0]  op_wd_sel_q;
    logic        op_we_q, op_regwrite_q, op_mis_q;
    logic [2:0]  op_funct3;

    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign memop     = !ex_bubble && (ex_wr || (ex_wD_sel == LOAD_SEL));
    assign op_funct3 = op_inst_q[14:12];

`ifdef MISALIGN_TRAP_EN
    // Size is funct3[1:0]: 00 byte, 01 half, anything else word.
    always_comb begin
        case (ex_inst[13:12])
            2'b00:   ex_mis = 1'b0;
            2'b01:   ex_mis = ex_C[0];
            default: ex_mis = (ex_C[1:0] != 2'b00);
        endcase
    end
`else
    assign ex_mis = 1'b0;
`endif

    // Next state, stall and request valid.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        dmem_req = 1'b0;
        case (state_q)
            StIdle: begin
                if (memop) begin
                    stall   = 1'b1;
                    state_d = ex_mis ? StDone : StReq;
                end
            end
            StReq: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = op_we_q ? StDone : StWait;
                end
            end
            StWait: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Store lane placement.
    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = op_wdata_q;
        case (op_funct3)
            3'b000: begin
                lane_strb  = 4'b0001 << op_addr_q[1:0];
                lane_wdata = {4{op_wdata_q[7:0]}};
            end
            3'b001: begin
                lane_strb  = 4'b0011 << {op_addr_q[1], 1'b0};
                lane_wdata = {2{op_wdata_q[15:0]}};
            end
            default: begin
                lane_strb  = 4'b1111;
                lane_wdata = op_wdata_q;
            end
        endcase
    end

    assign dmem_we    = dmem_req && op_we_q;
    assign dmem_addr  = {op_addr_q[31:2], 2'b00};
    assign dmem_wdata = lane_wdata;
    assign dmem_wstrb = dmem_we ? lane_strb : 4'b0000;

    // Load extraction and extension.
    always_comb begin
        case (op_addr_q[1:0])
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = op_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h000000, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0000, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            op_addr_q     <= '0;
            op_wdata_q    <= '0;
            op_pc4_q      <= '0;
            op_imm_q      <= '0;
            op_inst_q     <= '0;
            op_rdata_q    <= '0;
            op_wd_sel_q   <= '0;
            op_we_q       <= 1'b0;
            op_regwrite_q <= 1'b0;
            op_mis_q      <= 1'b0;
            wb_C          <= '0;
            wb_rdata      <= '0;
            wb_pc4        <= '0;
            wb_imm        <= '0;
            wb_inst       <= '0;
            wb_wD_sel     <= '0;
            wb_RegWrite   <= 1'b0;
            wb_bubble     <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (!memop) begin
                        wb_C        <= ex_C;
                        wb_rdata    <= '0;
                        wb_pc4      <= ex_pc4;
                        wb_imm      <= ex_imm;
                        wb_inst     <= ex_inst;
                        wb_wD_sel   <= ex_wD_sel;
                        wb_RegWrite <= ex_RegWrite;
                        wb_bubble   <= ex_bubble;
                    end else begin
                        op_addr_q     <= ex_C;
                        op_wdata_q    <= ex_rD2;
                        op_pc4_q      <= ex_pc4;
                        op_imm_q      <= ex_imm;
                        op_inst_q     <= ex_inst;
                        op_rdata_q    <= '0;
                        op_wd_sel_q   <= ex_wD_sel;
                        op_we_q       <= ex_wr;
                        op_regwrite_q <= ex_RegWrite;
                        op_mis_q      <= ex_mis;
                        wb_bubble     <= 1'b1;
                        wb_RegWrite   <= 1'b0;
                    end
                end
                StWait: begin
                    if (dmem_rvalid) begin
                        op_rdata_q <= load_data;
                    end
                end
                StDone: begin
                    // ex_* is ignored here: upstream advances at this edge.
                    wb_C        <= op_addr_q;
                    wb_rdata    <= op_rdata_q;
                    wb_pc4      <= op_pc4_q;
                    wb_imm      <= op_imm_q;
                    wb_inst     <= op_inst_q;
                    wb_wD_sel   <= op_wd_sel_q;
                    wb_RegWrite <= op_regwrite_q && !op_mis_q;
                    wb_bubble   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Pulses alongside the retiring faulting op's MEM/WB bundle.
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == StDone) && op_mis_q;
        end
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule
